dmem_arbiter: RTL and testbench

- Shares the single-port 1024-word data memory between two requesters: the RV32I core load/store port (C) and a host/loader port (H).
- H preloads data, or dumps results, while the core runs.
- Arbitrates per cycle, issues one memory access per cycle, and routes the 1-cycle-latency read data back to the owner of the read.
- Sits between the core datapath and the data_memory instance.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
// Owner encoding is used for both the round-robin pointer and the read-response tag.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  // req/gnt bit 0 is the core, bit 1 is the host; contention goes to the side not named by last
  function automatic logic [1:0] rr_grant2(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OWN_CORE) ? 2'b10 : 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (core/host) arbiter in front of a single-port 1-cycle-latency data memory.
// Round-robin by default; define DMEM_ARB_CORE_PRIO_EN for fixed core priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,

  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,

  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  logic [1:0] gnt;
  logic       rd_pend;
  logic       rd_owner;

`ifdef DMEM_ARB_CORE_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = {h_req & ~c_req, c_req};
    end
  end
`else
  logic last_gnt;

  // Grants are held low while reset is asserted even though requests may be present
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = rr_grant2({h_req, c_req}, last_gnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= OWN_HOST;
    end else if (gnt[0]) begin
      last_gnt <= OWN_CORE;
    end else if (gnt[1]) begin
      last_gnt <= OWN_HOST;
    end
  end
`endif

  assign c_gnt   = gnt[0];
  assign h_gnt   = gnt[1];
  assign c_stall = c_req & ~gnt[0];
  assign m_en    = gnt[0] | gnt[1];

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt[0]) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (gnt[1]) begin
      m_we    = h_we;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end
  end

  // Tag each read with its owner so the response lands on the right port next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CORE;
    end else begin
      rd_pend <= m_en & ~m_we;
      if (m_en & ~m_we) begin
        rd_owner <= gnt[1] ? OWN_HOST : OWN_CORE;
      end
    end
  end

  assign c_rvalid = rd_pend & (rd_owner == OWN_CORE);
  assign h_rvalid = rd_pend & (rd_owner == OWN_HOST);
  assign c_rdata  = m_rdata;
  assign h_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a turn-based reference model and a shadow memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = DMEM_ADDR_W;
  localparam int DW = DMEM_DATA_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          h_req = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          c_gnt, c_stall, c_rvalid, h_gnt, h_rvalid;
  logic [DW-1:0] c_rdata, h_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state: c_turn = core is preferred on the next contention
  bit            c_turn = 1'b1;
  bit            exp_pend = 1'b0;
  bit            exp_owner_host = 1'b0;
  bit            exp_known = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] ref_mem [0:1023];
  bit            ref_known [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Behavioural single-port memory with one cycle of read latency
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end

  function automatic logic [1:0] model_grant(bit cr, bit hr);
`ifdef DMEM_ARB_CORE_PRIO_EN
    return {hr && !cr, cr};
`else
    if (cr && hr) return c_turn ? 2'b01 : 2'b10;
    return {hr, cr};
`endif
  endfunction

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    c_turn = 1'b1;
    exp_pend = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd3; c_wdata = 32'h7;
    h_req = 1'b1; h_we = 1'b0; h_addr = 10'd4;
    #1;
    checks++; if (c_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_gnt: got %b expected 0", c_gnt); end
    checks++; if (h_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_h_gnt: got %b expected 0", h_gnt); end
    checks++; if (m_en !== 1'b0 || m_we !== 1'b0 || m_addr !== '0 || m_wdata !== '0) begin
      errors++; $display("[TB] FAIL reset_mem_bus: got en=%b we=%b addr=%0d wdata=%h expected all 0", m_en, m_we, m_addr, m_wdata);
    end
    checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rvalid: got c=%b h=%b expected 0 0", c_rvalid, h_rvalid);
    end
    checks++; if (c_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_c_stall: got %b expected 1", c_stall); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    c_turn = 1'b1;
    exp_pend = 1'b0;
  endtask

  task automatic test_core_only();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd5; c_wdata = 32'h2A;
    #1;
    checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0 || c_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL core_write_gnt: got c_gnt=%b h_gnt=%b stall=%b expected 1 0 0", c_gnt, h_gnt, c_stall);
    end
    checks++; if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 10'd5 || m_wdata !== 32'h2A) begin
      errors++; $display("[TB] FAIL core_write_bus: got en=%b we=%b addr=%0d wdata=%h expected 1 1 5 2a", m_en, m_we, m_addr, m_wdata);
    end
    @(negedge clk);
    c_we = 1'b0;
    #1;
    checks++; if (c_gnt !== 1'b1 || m_we !== 1'b0 || m_addr !== 10'd5) begin
      errors++; $display("[TB] FAIL core_read_bus: got gnt=%b we=%b addr=%0d expected 1 0 5", c_gnt, m_we, m_addr);
    end
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL core_write_no_rvalid: got %b expected 0", c_rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h2A || h_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL core_read_resp: got c_rvalid=%b c_rdata=%h h_rvalid=%b expected 1 2a 0", c_rvalid, c_rdata, h_rvalid);
    end
    checks++; if (m_en !== 1'b0) begin errors++; $display("[TB] FAIL core_idle_m_en: got %b expected 0", m_en); end
    @(negedge clk);
    #1;
    checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL core_rvalid_drop: got c=%b h=%b expected 0 0", c_rvalid, h_rvalid);
    end
  endtask

  task automatic test_contention();
    bit exp_c;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd1; c_wdata = 32'h11;
    @(negedge clk);
    idle_inputs();
    h_req = 1'b1; h_we = 1'b1; h_addr = 10'd2; h_wdata = 32'h22;
    do_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 10'd2;
    for (int k = 0; k < 4; k++) begin
      exp_c = (k % 2 == 0);
      #1;
      checks++; if (c_gnt !== exp_c || h_gnt !== !exp_c) begin
        errors++; $display("[TB] FAIL contention_gnt%0d: got c=%b h=%b expected c=%b h=%b", k, c_gnt, h_gnt, exp_c, !exp_c);
      end
      checks++; if (c_stall !== !exp_c || m_addr !== (exp_c ? 10'd1 : 10'd2)) begin
        errors++; $display("[TB] FAIL contention_stall%0d: got stall=%b addr=%0d expected stall=%b", k, c_stall, m_addr, !exp_c);
      end
      if (k > 0) begin
        checks++; if (c_rvalid !== !exp_c || h_rvalid !== exp_c || c_rdata !== (exp_c ? 32'h22 : 32'h11)) begin
          errors++; $display("[TB] FAIL contention_resp%0d: got c_rv=%b h_rv=%b data=%h", k, c_rvalid, h_rvalid, c_rdata);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (h_rvalid !== 1'b1 || c_rvalid !== 1'b0 || h_rdata !== 32'h22) begin
      errors++; $display("[TB] FAIL contention_last_resp: got h_rv=%b c_rv=%b h_rdata=%h expected 1 0 22", h_rvalid, c_rvalid, h_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    h_req = 1'b1; h_we = 1'b1; h_addr = 10'd10; h_wdata = 32'hA;
    #1;
    checks++; if (h_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hA) begin
      errors++; $display("[TB] FAIL b2b_host_write: got gnt=%b we=%b wdata=%h expected 1 1 a", h_gnt, m_we, m_wdata);
    end
    @(negedge clk);
    h_addr = 10'd11; h_wdata = 32'hB;
    @(negedge clk);
    h_we = 1'b0; h_addr = 10'd10;
    #1;
    checks++; if (h_gnt !== 1'b1 || m_addr !== 10'd10 || m_we !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_host_read_gnt: got gnt=%b addr=%0d we=%b expected 1 10 0", h_gnt, m_addr, m_we);
    end
    @(negedge clk);
    idle_inputs();
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd11;
    #1;
    checks++; if (c_gnt !== 1'b1 || h_rvalid !== 1'b1 || h_rdata !== 32'hA || c_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_host_resp: got c_gnt=%b h_rv=%b h_rdata=%h c_rv=%b expected 1 1 a 0", c_gnt, h_rvalid, h_rdata, c_rvalid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hB || h_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_core_resp: got c_rv=%b c_rdata=%h h_rv=%b expected 1 b 0", c_rvalid, c_rdata, h_rvalid);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd5;
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("[TB] FAIL midrst_gnt: got %b expected 1", c_gnt); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (c_gnt !== 1'b0 || m_en !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_gate: got c_gnt=%b m_en=%b expected 0 0", c_gnt, m_en);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
        errors++; $display("[TB] FAIL midrst_rvalid%0d: got c=%b h=%b expected 0 0", k, c_rvalid, h_rvalid);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    c_turn = 1'b1;
    exp_pend = 1'b0;
    #1;
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_release_rvalid: got %b expected 0", c_rvalid); end
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd5;
    h_req = 1'b1; h_we = 1'b0; h_addr = 10'd10;
    #1;
    checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_first_win: got c=%b h=%b expected 1 0", c_gnt, h_gnt);
    end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    checks++; if (h_gnt !== 1'b1 || c_rvalid !== 1'b1 || c_rdata !== 32'h2A) begin
      errors++; $display("[TB] FAIL midrst_follow: got h_gnt=%b c_rv=%b c_rdata=%h expected 1 1 2a", h_gnt, c_rvalid, c_rdata);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (h_rvalid !== 1'b1 || h_rdata !== 32'hA) begin
      errors++; $display("[TB] FAIL midrst_host_resp: got h_rv=%b h_rdata=%h expected 1 a", h_rvalid, h_rdata);
    end
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd21; c_wdata = 32'h77;
    do_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'd20; c_wdata = 32'h55;
    h_req = 1'b1; h_we = 1'b1; h_addr = 10'd21; h_wdata = 32'h66;
    #1;
    checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0 || m_addr !== 10'd20 || m_wdata !== 32'h55) begin
      errors++; $display("[TB] FAIL withdraw_gnt: got c=%b h=%b addr=%0d wdata=%h expected 1 0 20 55", c_gnt, h_gnt, m_addr, m_wdata);
    end
    @(negedge clk);
    h_req = 1'b0;
    c_we = 1'b0; c_addr = 10'd21;
    #1;
    checks++; if (h_gnt !== 1'b0 || c_gnt !== 1'b1 || m_addr !== 10'd21 || m_we !== 1'b0) begin
      errors++; $display("[TB] FAIL withdraw_after: got h=%b c=%b addr=%0d we=%b expected 0 1 21 0", h_gnt, c_gnt, m_addr, m_we);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h77) begin
      errors++; $display("[TB] FAIL withdraw_no_write: got c_rv=%b c_rdata=%h expected 1 77", c_rvalid, c_rdata);
    end
  endtask

`ifdef DMEM_ARB_CORE_PRIO_EN
  task automatic test_core_prio();
    do_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 10'd5;
    h_req = 1'b1; h_we = 1'b0; h_addr = 10'd10;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin
        errors++; $display("[TB] FAIL prio_cycle%0d: got c=%b h=%b expected 1 0", k, c_gnt, h_gnt);
      end
      @(negedge clk);
    end
    c_req = 1'b0;
    #1;
    checks++; if (h_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_host_turn: got h=%b c=%b expected 1 0", h_gnt, c_gnt);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    bit            cp, hp;
    logic [1:0]    g;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    cp = 1'b0; hp = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!cp) begin
        if ($urandom_range(0, 9) < 6) begin
          cp = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = AW'(100 + $urandom_range(0, 15)); c_wdata = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) cp = 1'b0;
      if (!hp) begin
        if ($urandom_range(0, 9) < 6) begin
          hp = 1'b1; h_we = 1'($urandom_range(0, 1));
          h_addr = AW'(100 + $urandom_range(0, 15)); h_wdata = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) hp = 1'b0;
      c_req = cp; h_req = hp;
      #1;
      checks++; if (c_rvalid !== (exp_pend && !exp_owner_host) || h_rvalid !== (exp_pend && exp_owner_host)) begin
        errors++; $display("[TB] FAIL rand_rvalid@%0d: got c=%b h=%b expected pend=%b host=%b", cyc, c_rvalid, h_rvalid, exp_pend, exp_owner_host);
      end
      if (exp_pend && exp_known) begin
        checks++; if ((exp_owner_host ? h_rdata : c_rdata) !== exp_data) begin
          errors++; $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", cyc, exp_owner_host ? h_rdata : c_rdata, exp_data);
        end
      end
      g = model_grant(cp, hp);
      checks++; if ({h_gnt, c_gnt} !== g || m_en !== (g != 2'b00) || c_stall !== (cp && !g[0])) begin
        errors++; $display("[TB] FAIL rand_gnt@%0d: got h/c=%b%b en=%b stall=%b expected %b", cyc, h_gnt, c_gnt, m_en, c_stall, g);
      end
      ew = g[0] ? c_we : (g[1] ? h_we : 1'b0);
      ea = g[0] ? c_addr : (g[1] ? h_addr : '0);
      ed = g[0] ? c_wdata : (g[1] ? h_wdata : '0);
      checks++; if (m_we !== ew || m_addr !== ea || m_wdata !== ed) begin
        errors++; $display("[TB] FAIL rand_bus@%0d: got we=%b addr=%0d wdata=%h expected %b %0d %h", cyc, m_we, m_addr, m_wdata, ew, ea, ed);
      end
      exp_pend = 1'b0;
      if (g != 2'b00) begin
        c_turn = g[1];
        if (ew) begin
          ref_mem[ea] = ed; ref_known[ea] = 1'b1;
        end else begin
          exp_pend = 1'b1; exp_owner_host = g[1];
          exp_known = ref_known[ea]; exp_data = ref_mem[ea];
        end
        if (g[0]) cp = 1'b0;
        if (g[1]) hp = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_core_only();
`ifndef DMEM_ARB_CORE_PRIO_EN
    test_contention();
`endif
    test_back_to_back();
    test_reset_mid_read();
    test_withdrawn();
`ifdef DMEM_ARB_CORE_PRIO_EN
    test_core_prio();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
